app_in_fifo: RTL and testbench

APP_IN_FIFO -- requirements
Module: app_in_fifo

---
 rtl/app_in_fifo.sv | 123 ++++++++++++
 tb/tb_app_in_fifo.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/app_in_fifo.sv
//------------------------------------------------------------------------------
// Module      : app_in_fifo
// Description : Byte FIFO between an application source and a bulk IN
//               endpoint. Register-array storage with wrap-bit pointers,
//               occupancy level and empty/full/almost-full flags.
//               Optional feature macro: APP_IN_FIFO_OVF_DROP_EN
//                 defined   -> s_ready_o held high outside reset; writes into
//                              a full FIFO are dropped and counted (ovf_cnt_o,
//                              saturating).
//                 undefined -> s_ready_o = ~full_o, ovf_cnt_o tied to zero.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module app_in_fifo #(
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic [7:0]                 s_data_i,
    input  logic                       s_valid_i,
    output logic                       s_ready_o,
    output logic [7:0]                 m_data_o,
    output logic                       m_valid_o,
    input  logic                       m_ready_i,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic                       afull_o,
    output logic [15:0]                ovf_cnt_o
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_PW = c_AW + 1;
    localparam logic [c_PW-1:0] c_DEPTH_LVL = c_PW'(DEPTH);
    localparam logic [c_PW-1:0] c_AFULL_LVL = c_PW'(AFULL_LEVEL);

    logic [7:0]      r_mem [DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;

    logic [c_PW-1:0] w_level;
    logic            w_empty;
    logic            w_full;
    logic            w_s_ready;
    logic            w_rd_en;
    logic            w_wr_en;

    // Status derived purely from the registered pointers
    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_empty = (w_level == '0);
    assign w_full  = (w_level == c_DEPTH_LVL);

    // A read needs a byte already stored, so an incoming byte can never be
    // consumed in the cycle it is written.
    assign w_rd_en = ~w_empty & m_ready_i;

`ifdef APP_IN_FIFO_OVF_DROP_EN
    logic [15:0] r_ovf_cnt;
    logic        w_drop;

    // Always ready outside reset; a write into a full FIFO is only stored
    // when a read frees a slot in the same cycle, otherwise it is dropped.
    assign w_s_ready = ~rst_i;
    assign w_wr_en   = s_valid_i & w_s_ready & (~w_full | w_rd_en);
    assign w_drop    = s_valid_i & w_s_ready & w_full & ~w_rd_en;

    // Saturating count of dropped bytes; flush leaves it untouched
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ovf_cnt <= 16'd0;
        end else if (w_drop && !flush_i && (r_ovf_cnt != 16'hFFFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 16'd1;
        end
    end

    assign ovf_cnt_o = r_ovf_cnt;
`else
    // Backpressure when full; no overflow accounting exists
    assign w_s_ready = ~w_full;
    assign w_wr_en   = s_valid_i & w_s_ready;
    assign ovf_cnt_o = 16'd0;
`endif

    // Pointer update: reset beats flush, flush beats any transfer
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
        end
    end

    // Storage array: cleared on reset, written at the write pointer slot
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'd0;
            end
        end else if (w_wr_en && !flush_i) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= s_data_i;
        end
    end

    assign s_ready_o = w_s_ready;
    assign m_data_o  = r_mem[r_rd_ptr[c_AW-1:0]];
    assign m_valid_o = ~w_empty;
    assign level_o   = w_level;
    assign empty_o   = w_empty;
    assign full_o    = w_full;
    assign afull_o   = (w_level >= c_AFULL_LVL);

endmodule

`default_nettype wire

// File: tb/tb_app_in_fifo.sv
//------------------------------------------------------------------------------
// Module      : tb_app_in_fifo
// Description : Directed self-checking bench for app_in_fifo (DEPTH=16,
//               AFULL_LEVEL=12). Expectations follow APP_IN_FIFO_OVF_DROP_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_app_in_fifo;

    logic        clk_i;
    logic        rst_i;
    logic        flush_i;
    logic [7:0]  s_data_i;
    logic        s_valid_i;
    logic        s_ready_o;
    logic [7:0]  m_data_o;
    logic        m_valid_o;
    logic        m_ready_i;
    logic [4:0]  level_o;
    logic        empty_o;
    logic        full_o;
    logic        afull_o;
    logic [15:0] ovf_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

`ifdef APP_IN_FIFO_OVF_DROP_EN
    localparam bit c_DROP = 1'b1;
`else
    localparam bit c_DROP = 1'b0;
`endif

    app_in_fifo #(
        .DEPTH       (16),
        .AFULL_LEVEL (12)
    ) u_dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush_i   (flush_i),
        .s_data_i  (s_data_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .m_data_o  (m_data_o),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .level_o   (level_o),
        .empty_o   (empty_o),
        .full_o    (full_o),
        .afull_o   (afull_o),
        .ovf_cnt_o (ovf_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle past it
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_vals(input string tag, input logic exp_srdy);
        check({tag, " m_valid"}, 32'(m_valid_o), 32'd0);
        check({tag, " empty"},   32'(empty_o),   32'd1);
        check({tag, " full"},    32'(full_o),    32'd0);
        check({tag, " afull"},   32'(afull_o),   32'd0);
        check({tag, " level"},   32'(level_o),   32'd0);
        check({tag, " ovf"},     32'(ovf_cnt_o), 32'd0);
        check({tag, " m_data"},  32'(m_data_o),  32'd0);
        check({tag, " s_ready"}, 32'(s_ready_o), 32'(exp_srdy));
    endtask

    task automatic push(input logic [7:0] d);
        s_valid_i = 1'b1;
        s_data_i  = d;
        step();
        s_valid_i = 1'b0;
    endtask

    initial begin
        rst_i     = 1'b1;
        flush_i   = 1'b0;
        s_data_i  = 8'd0;
        s_valid_i = 1'b0;
        m_ready_i = 1'b0;
        step();
        step();
        check_reset_vals("rst_during", ~c_DROP);
        rst_i = 1'b0;
        step();
        check_reset_vals("rst_after", 1'b1);

        // Single byte, consumer stalled: visible the next cycle
        push(8'h41);
        check("one m_valid", 32'(m_valid_o), 32'd1);
        check("one m_data",  32'(m_data_o),  32'h41);
        check("one level",   32'(level_o),   32'd1);
        check("one empty",   32'(empty_o),   32'd0);
        m_ready_i = 1'b1;
        step();
        m_ready_i = 1'b0;
        check("one drained", 32'(empty_o), 32'd1);

        // Fill to DEPTH, watching afull cross at 12
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            check("fill level", 32'(level_o), 32'(i + 1));
            check("fill afull", 32'(afull_o), 32'((i + 1) >= 12));
        end
        check("fill full",    32'(full_o),    32'd1);
        check("fill s_ready", 32'(s_ready_o), 32'(c_DROP));

        // Drain in order
        m_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain data", 32'(m_data_o), 32'(i));
            step();
        end
        m_ready_i = 1'b0;
        check("drain empty", 32'(empty_o), 32'd1);

        // Full FIFO, simultaneous read and write
        for (int i = 0; i < 16; i++) begin
            push(8'(8'h80 + i));
        end
        s_valid_i = 1'b1;
        s_data_i  = 8'hAA;
        m_ready_i = 1'b1;
        step();
        s_valid_i = 1'b0;
        m_ready_i = 1'b0;
        check("fullrw level", 32'(level_o),   c_DROP ? 32'd16 : 32'd15);
        check("fullrw ovf",   32'(ovf_cnt_o), 32'd0);
        if (!c_DROP) begin
            push(8'hAA);
        end

        // Three writes into a full FIFO with the consumer stalled
        for (int i = 0; i < 3; i++) begin
            push(8'h55);
        end
        check("ovf count", 32'(ovf_cnt_o), c_DROP ? 32'd3 : 32'd0);
        check("ovf level", 32'(level_o),   32'd16);
        m_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("ovf data", 32'(m_data_o), (i < 15) ? 32'(8'h81 + i) : 32'hAA);
            step();
        end
        m_ready_i = 1'b0;

        // Continuous stream across pointer wrap: level holds at 1
        m_ready_i = 1'b1;
        for (int i = 0; i <= 40; i++) begin
            if (i > 0) begin
                check("stream data",  32'(m_data_o), 32'(i - 1));
                check("stream level", 32'(level_o),  32'd1);
            end
            s_valid_i = (i < 40);
            s_data_i  = 8'(i);
            step();
        end
        s_valid_i = 1'b0;
        m_ready_i = 1'b0;
        check("stream empty", 32'(empty_o), 32'd1);

        // Level 5, then flush together with a write
        for (int i = 0; i < 5; i++) begin
            push(8'(8'h10 + i));
        end
        check("pre-flush level", 32'(level_o), 32'd5);
        flush_i   = 1'b1;
        s_valid_i = 1'b1;
        s_data_i  = 8'h77;
        step();
        flush_i   = 1'b0;
        s_valid_i = 1'b0;
        check("flush level",   32'(level_o),   32'd0);
        check("flush empty",   32'(empty_o),   32'd1);
        check("flush m_valid", 32'(m_valid_o), 32'd0);
        check("flush ovf",     32'(ovf_cnt_o), c_DROP ? 32'd3 : 32'd0);

        // Reset in the middle of traffic discards everything
        for (int i = 0; i < 3; i++) begin
            push(8'(8'hC0 + i));
        end
        check("pre-rst level", 32'(level_o), 32'd3);
        rst_i     = 1'b1;
        s_valid_i = 1'b1;
        s_data_i  = 8'h99;
        step();
        s_valid_i = 1'b0;
        check_reset_vals("midrst_during", ~c_DROP);
        rst_i = 1'b0;
        step();
        check_reset_vals("midrst_after", 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
